// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared fetch-path constants used by the prefetch / decode queue.
//   FQ_INSN_WIDTH   width of one instruction word
//   FQ_LGDEPTH      default log2 depth of the fetch queue
//   fq_entry_width  width of one queued entry {illegal, pc, insn}
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

   localparam int unsigned FQ_INSN_WIDTH = 32;
   localparam int unsigned FQ_LGDEPTH    = 2;

   // One entry carries the illegal flag, the PC and the instruction word.
   function automatic int unsigned fq_entry_width(input int unsigned aw);
      return 1 + aw + FQ_INSN_WIDTH;
   endfunction

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// In-order instruction queue between the prefetch stage and decode, with a
// first-word-fall-through head. Flushed on a branch or a cache clear.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_new_pc            branch taken, drop all queued entries
//   i_clear_cache       cache clear, drop all queued entries
//   i_pf_valid          prefetch word valid
//   i_pf_insn/pc/illegal  prefetch word contents
//   o_pf_stalled_n      queue can accept a word this cycle
//   o_valid             head entry valid
//   o_insn/pc/illegal   head entry contents (don't-care when !o_valid)
//   i_dec_stalled_n     decode consumes the head this cycle
//   o_fill              current occupancy
// -----------------------------------------------------------------------------
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned LGDEPTH       = FQ_LGDEPTH
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_new_pc,
   input  logic                      i_clear_cache,
   input  logic                      i_pf_valid,
   input  logic [FQ_INSN_WIDTH-1:0]  i_pf_insn,
   input  logic [ADDRESS_WIDTH-1:0]  i_pf_pc,
   input  logic                      i_pf_illegal,
   output logic                      o_pf_stalled_n,
   output logic                      o_valid,
   output logic [FQ_INSN_WIDTH-1:0]  o_insn,
   output logic [ADDRESS_WIDTH-1:0]  o_pc,
   output logic                      o_illegal,
   input  logic                      i_dec_stalled_n,
   output logic [LGDEPTH:0]          o_fill
);

   localparam int unsigned EW    = fq_entry_width(ADDRESS_WIDTH);
   localparam int unsigned DEPTH = 1 << LGDEPTH;
   localparam logic [LGDEPTH:0] FULL_FILL = (LGDEPTH+1)'(DEPTH);

   // Pointers carry one extra MSB so full and empty are distinguishable.
   logic [LGDEPTH:0] wr_ptr_q, wr_ptr_d;
   logic [LGDEPTH:0] rd_ptr_q, rd_ptr_d;
   logic [EW-1:0]    mem_q [DEPTH];
   logic [EW-1:0]    head;

   logic full, empty, flush, push, pop;

   assign o_fill = wr_ptr_q - rd_ptr_q;
   assign full   = (o_fill == FULL_FILL);
   assign empty  = (o_fill == '0);
   assign flush  = i_new_pc || i_clear_cache;

   // Acceptance depends only on registered pointers: no push into a full
   // queue even if decode pops in the same cycle.
   assign o_pf_stalled_n = !full;
   assign o_valid        = !empty;
   assign push           = i_pf_valid && o_pf_stalled_n;
   assign pop            = o_valid && i_dec_stalled_n;

   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned, which would infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         // Drop everything; a push in the same cycle is discarded.
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; its contents are
   // only observed through valid pointers, and leaving out the reset lets it
   // map to plain flops or LUT-RAM.
   always_ff @(posedge i_clk) begin
      if (!i_rst && push && !flush)
         mem_q[wr_ptr_q[LGDEPTH-1:0]] <= {i_pf_illegal, i_pf_pc, i_pf_insn};
   end

   assign head      = mem_q[rd_ptr_q[LGDEPTH-1:0]];
   assign o_insn    = head[FQ_INSN_WIDTH-1:0];
   assign o_pc      = head[FQ_INSN_WIDTH +: ADDRESS_WIDTH];
   assign o_illegal = head[EW-1];

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Directed stimulus for fetch_queue. Each accepted push places its expected
// entry in a scoreboard; a monitor on the falling edge pops and compares the
// head whenever decode consumes it.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

   localparam int AW = 32;
   localparam int LG = 2;

   logic            i_clk = 1'b0;
   logic            i_rst;
   logic            i_new_pc;
   logic            i_clear_cache;
   logic            i_pf_valid;
   logic [31:0]     i_pf_insn;
   logic [AW-1:0]   i_pf_pc;
   logic            i_pf_illegal;
   logic            o_pf_stalled_n;
   logic            o_valid;
   logic [31:0]     o_insn;
   logic [AW-1:0]   o_pc;
   logic            o_illegal;
   logic            i_dec_stalled_n;
   logic [LG:0]     o_fill;

   fetch_queue #(.ADDRESS_WIDTH(AW), .LGDEPTH(LG)) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_new_pc        (i_new_pc),
      .i_clear_cache   (i_clear_cache),
      .i_pf_valid      (i_pf_valid),
      .i_pf_insn       (i_pf_insn),
      .i_pf_pc         (i_pf_pc),
      .i_pf_illegal    (i_pf_illegal),
      .o_pf_stalled_n  (o_pf_stalled_n),
      .o_valid         (o_valid),
      .o_insn          (o_insn),
      .o_pc            (o_pc),
      .o_illegal       (o_illegal),
      .i_dec_stalled_n (i_dec_stalled_n),
      .o_fill          (o_fill)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [AW-1:0] pc;
      logic [31:0]   insn;
      logic          ill;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Drive a prefetch word; record it as expected only when the caller says
   // the queue will take it.
   task automatic drive_pf(input logic v, input logic [AW-1:0] pc,
                           input logic [31:0] insn, input logic ill,
                           input logic expect_accept);
      exp_t e;
      i_pf_valid   = v;
      i_pf_pc      = pc;
      i_pf_insn    = insn;
      i_pf_illegal = ill;
      if (v && expect_accept) begin
         e.pc = pc; e.insn = insn; e.ill = ill;
         sb.push_back(e);
      end
   endtask

   // Monitor: compare the head against the scoreboard whenever it is consumed.
   always @(negedge i_clk) begin
      exp_t e;
      if (!i_rst && !i_new_pc && !i_clear_cache && o_valid && i_dec_stalled_n) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pop: got pc 0x%0h expected none at %0t", o_pc, $time);
         end else begin
            e = sb.pop_front();
            check("head_pc",      64'(o_pc),      64'(e.pc));
            check("head_insn",    64'(o_insn),    64'(e.insn));
            check("head_illegal", 64'(o_illegal), 64'(e.ill));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst = 1'b1; i_new_pc = 1'b0; i_clear_cache = 1'b0;
      i_dec_stalled_n = 1'b0;
      drive_pf(1'b0, '0, '0, 1'b0, 1'b0);
      step(); step();
      i_rst = 1'b0;
      check("rst_valid",     64'(o_valid),        64'd0);
      check("rst_fill",      64'(o_fill),         64'd0);
      check("rst_stalled_n", 64'(o_pf_stalled_n), 64'd1);

      // Fill with decode stalled.
      for (int k = 0; k < 4; k++) begin
         drive_pf(1'b1, AW'(32'h100 + k), 32'hA000_0000 + k, 1'b0, 1'b1);
         step();
      end
      check("full_fill",      64'(o_fill),         64'd4);
      check("full_stalled_n", 64'(o_pf_stalled_n), 64'd0);
      // Fifth word must be refused.
      drive_pf(1'b1, AW'(32'h104), 32'hA000_0004, 1'b0, 1'b0);
      step();
      check("full_refuse_fill", 64'(o_fill), 64'd4);
      drive_pf(1'b0, '0, '0, 1'b0, 1'b0);

      // Drain in order; space reopens one cycle after the first pop.
      i_dec_stalled_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         if (k == 0) check("recover_stalled_n", 64'(o_pf_stalled_n), 64'd1);
      end
      i_dec_stalled_n = 1'b0;
      check("drain_valid", 64'(o_valid), 64'd0);
      check("drain_fill",  64'(o_fill),  64'd0);

      // Streaming: one push and one pop per cycle, pointers wrap repeatedly.
      i_dec_stalled_n = 1'b1;
      for (int k = 0; k < 21; k++) begin
         drive_pf(1'b1, AW'(32'h400 + k), 32'hB000_0000 + k, 1'b0, 1'b1);
         step();
         check("stream_fill", 64'(o_fill), 64'd1);
      end
      drive_pf(1'b0, '0, '0, 1'b0, 1'b0);
      step();
      i_dec_stalled_n = 1'b0;
      check("stream_end_valid", 64'(o_valid), 64'd0);

      // Flush with a simultaneous push.
      for (int k = 0; k < 3; k++) begin
         drive_pf(1'b1, AW'(32'h500 + k), 32'hC000_0000 + k, 1'b0, 1'b1);
         step();
      end
      check("preflush_fill", 64'(o_fill), 64'd3);
      i_new_pc = 1'b1;
      sb.delete();
      drive_pf(1'b1, AW'(32'h200), 32'hDEAD_0200, 1'b0, 1'b0);
      step();
      i_new_pc = 1'b0;
      check("flush_fill",  64'(o_fill),  64'd0);
      check("flush_valid", 64'(o_valid), 64'd0);
      drive_pf(1'b1, AW'(32'h600), 32'hC000_0600, 1'b0, 1'b1);
      step();
      drive_pf(1'b0, '0, '0, 1'b0, 1'b0);
      check("postflush_fill", 64'(o_fill), 64'd1);
      i_dec_stalled_n = 1'b1;
      step();
      i_dec_stalled_n = 1'b0;

      // Cache clear also empties the queue.
      drive_pf(1'b1, AW'(32'h610), 32'hC000_0610, 1'b0, 1'b1);
      step();
      i_clear_cache = 1'b1;
      sb.delete();
      drive_pf(1'b0, '0, '0, 1'b0, 1'b0);
      step();
      i_clear_cache = 1'b0;
      check("clear_valid", 64'(o_valid), 64'd0);

      // Illegal flag passes through untouched.
      drive_pf(1'b1, AW'(32'h300), 32'hE000_0300, 1'b1, 1'b1);
      step();
      drive_pf(1'b1, AW'(32'h301), 32'hE000_0301, 1'b0, 1'b1);
      step();
      drive_pf(1'b0, '0, '0, 1'b0, 1'b0);
      check("ill_head_flag", 64'(o_illegal), 64'd1);
      check("ill_head_pc",   64'(o_pc),      64'h300);
      i_dec_stalled_n = 1'b1;
      step();
      check("ill_next_flag", 64'(o_illegal), 64'd0);
      step();
      i_dec_stalled_n = 1'b0;

      // Reset during a push and pop.
      drive_pf(1'b1, AW'(32'h700), 32'hF000_0700, 1'b0, 1'b1);
      step();
      drive_pf(1'b1, AW'(32'h701), 32'hF000_0701, 1'b0, 1'b1);
      step();
      check("prerst_fill", 64'(o_fill), 64'd2);
      i_rst = 1'b1;
      i_dec_stalled_n = 1'b1;
      sb.delete();
      drive_pf(1'b1, AW'(32'h702), 32'hF000_0702, 1'b0, 1'b0);
      step();
      i_rst = 1'b0;
      i_dec_stalled_n = 1'b0;
      drive_pf(1'b0, '0, '0, 1'b0, 1'b0);
      check("midrst_fill",      64'(o_fill),         64'd0);
      check("midrst_valid",     64'(o_valid),        64'd0);
      check("midrst_stalled_n", 64'(o_pf_stalled_n), 64'd1);

      step();
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fetch_queue
